// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute/writeback sequencer.
// Owns the PC, fetches 32-bit words over a req/ack instruction-memory port,
// latches the IR and drives ALU-op, register-write strobe and write-mux selects.
// Optional build macro PERF_CNT_EN adds busy-cycle and retired-instruction counters.
module instr_sequencer #(
    parameter int            AW          = 8,
    parameter logic [AW-1:0] RESET_PC    = '0,
    parameter int            MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    output logic          o_imem_req,
    output logic [AW-1:0] o_imem_addr,
    input  logic          i_imem_ack,
    input  logic [31:0]   i_imem_rdata,
    output logic [31:0]   o_instr,
    output logic [3:0]    o_alu_op,
    output logic          o_reg_write,
    output logic          o_mux_write_reg,
    output logic          o_mux_write_data,
    output logic          o_busy,
    output logic          o_halted,
    output logic          o_fault
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]   o_cycle_cnt,
    output logic [31:0]   o_retire_cnt
`endif
);

    // Opcode encodings (IR[31:27])
    localparam logic [4:0] OP_AR  = 5'b00010;
    localparam logic [4:0] OP_T   = 5'b01011;
    localparam logic [4:0] OP_HLT = 5'b11111;

    // Largest legal AR function code
    localparam logic [3:0] AR_FUNCT_MAX = 4'b1000;

    // Timeout counter sized to hold MEM_TIMEOUT-1; at least one bit wide
    localparam int            TW      = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = (MEM_TIMEOUT == 0) ? '0 : TW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [31:0]   r_instr;
    logic [3:0]    r_alu_op;
    logic          r_mux_wr;
    logic          r_mux_wd;
    logic          r_wr_pend;
    logic          r_halt_pend;
    logic          r_imem_req;
    logic          r_reg_write;
    logic          r_busy;
    logic          r_halted;
    logic          r_fault;
    logic [TW-1:0] r_to_cnt;

    logic [4:0]    w_opcode;
    logic [3:0]    w_funct;
    logic [3:0]    w_dec_alu;
    logic          w_dec_mwr;
    logic          w_dec_mwd;
    logic          w_dec_wr;
    logic          w_dec_halt;
    logic          w_dec_illegal;
    logic          w_timeout;

    assign w_opcode  = r_instr[31:27];
    assign w_funct   = r_instr[3:0];
    assign w_timeout = (MEM_TIMEOUT != 0) && (r_to_cnt == TO_LAST);

    // Decode the latched IR into next control values; unlisted controls hold
    always_comb begin
        w_dec_alu     = r_alu_op;
        w_dec_mwr     = r_mux_wr;
        w_dec_mwd     = r_mux_wd;
        w_dec_wr      = 1'b0;
        w_dec_halt    = 1'b0;
        w_dec_illegal = 1'b0;
        case (w_opcode)
            OP_AR: begin
                if (w_funct > AR_FUNCT_MAX) begin
                    w_dec_illegal = 1'b1;
                end else begin
                    w_dec_alu = w_funct;
                    w_dec_wr  = 1'b1;
                    w_dec_mwr = 1'b0;
                    w_dec_mwd = 1'b0;
                end
            end
            OP_T: begin
                w_dec_alu = 4'b1111;
                w_dec_wr  = 1'b1;
                w_dec_mwr = 1'b1;
                w_dec_mwd = 1'b1;
            end
            OP_HLT: begin
                w_dec_halt = 1'b1;
            end
            default: begin
                w_dec_illegal = 1'b1;
            end
        endcase
    end

    // Main sequencer: state, PC, IR and all registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_alu_op    <= '0;
            r_mux_wr    <= 1'b0;
            r_mux_wd    <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_halt_pend <= 1'b0;
            r_imem_req  <= 1'b0;
            r_reg_write <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (i_start) begin
                        r_state    <= S_FETCH;
                        r_pc       <= RESET_PC;
                        r_fault    <= 1'b0;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                        r_halted   <= 1'b0;
                        r_to_cnt   <= '0;
                    end
                end
                S_FETCH: begin
                    // An ack in the final allowed cycle still wins over the timeout
                    if (i_imem_ack) begin
                        r_instr    <= i_imem_rdata;
                        r_imem_req <= 1'b0;
                        r_to_cnt   <= '0;
                        r_state    <= S_DECODE;
                    end else if (w_timeout) begin
                        r_fault    <= 1'b1;
                        r_imem_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_halted   <= 1'b1;
                        r_to_cnt   <= '0;
                        r_state    <= S_HALT;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                S_DECODE: begin
                    r_alu_op    <= w_dec_alu;
                    r_mux_wr    <= w_dec_mwr;
                    r_mux_wd    <= w_dec_mwd;
                    r_wr_pend   <= w_dec_wr;
                    r_halt_pend <= w_dec_halt;
                    if (w_dec_illegal) begin
                        r_fault <= 1'b1;
                    end
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    // HLT stops here without advancing the PC
                    if (r_halt_pend) begin
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_reg_write <= r_wr_pend;
                        r_state     <= S_WB;
                    end
                end
                S_WB: begin
                    r_reg_write <= 1'b0;
                    r_pc        <= r_pc + AW'(1);
                    r_imem_req  <= 1'b1;
                    r_state     <= S_FETCH;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_imem_req  <= 1'b0;
                    r_reg_write <= 1'b0;
                    r_busy      <= 1'b0;
                    r_halted    <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req       = r_imem_req;
    assign o_imem_addr      = r_pc;
    assign o_instr          = r_instr;
    assign o_alu_op         = r_alu_op;
    assign o_reg_write      = r_reg_write;
    assign o_mux_write_reg  = r_mux_wr;
    assign o_mux_write_data = r_mux_wd;
    assign o_busy           = r_busy;
    assign o_halted         = r_halted;
    assign o_fault          = r_fault;

`ifdef PERF_CNT_EN
    logic        w_start_acc;
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_retire_cnt;

    assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_HALT));

    // Saturating busy-cycle and retired-instruction counters, cleared on accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else if (w_start_acc) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (r_busy && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if ((r_state == S_WB) && (r_retire_cnt != 32'hFFFF_FFFF)) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign o_cycle_cnt  = r_cycle_cnt;
    assign o_retire_cnt = r_retire_cnt;
`else
    // Performance counters are not built in this configuration
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed programs, scoreboard of expected
// fetch addresses and register writes checked by independent monitors.
module tb_instr_sequencer;

    localparam logic [4:0] OP_AR  = 5'b00010;
    localparam logic [4:0] OP_T   = 5'b01011;
    localparam logic [4:0] OP_ILL = 5'b00111;
    localparam logic [4:0] OP_HLT = 5'b11111;

    typedef struct packed {
        logic [3:0]  alu;
        logic        mwr;
        logic        mwd;
        logic [31:0] ir;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start1 = 1'b0;

    logic        req, ack, reg_write, mwr, mwd, busy, halted, fault;
    logic [7:0]  addr;
    logic [31:0] rdata, instr;
    logic [3:0]  alu_op;

    logic        req1, ack1, reg_write1, mwr1, mwd1, busy1, halted1, fault1;
    logic [1:0]  addr1;
    logic [31:0] rdata1, instr1;
    logic [3:0]  alu_op1;

`ifdef PERF_CNT_EN
    logic [31:0] cyc, ret, cyc1, ret1;
`endif

    int total = 0;
    int bad   = 0;
    int wr_seen = 0;
    int wr_before;

    logic [31:0] mem  [0:255];
    logic [31:0] mem1 [0:3];
    int          ack_delay = 0;
    int          wait_cnt  = 0;

    wr_t         exp_wr[$];
    int          exp_fetch[$];
    int          exp_fetch1[$];
    logic [3:0]  exp_alu1[$];

    always #5 clk = ~clk;

    // Instruction memory models: main one acks after ack_delay wait cycles (-1 = never)
    assign ack    = req && (ack_delay >= 0) && (wait_cnt == ack_delay);
    assign rdata  = mem[addr];
    assign ack1   = req1;
    assign rdata1 = mem1[addr1];

    always @(posedge clk) begin
        if (req && !ack) wait_cnt <= wait_cnt + 1;
        else             wait_cnt <= 0;
    end

    instr_sequencer #(.AW(8), .RESET_PC(8'd0), .MEM_TIMEOUT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(start),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
        .o_instr(instr), .o_alu_op(alu_op), .o_reg_write(reg_write),
        .o_mux_write_reg(mwr), .o_mux_write_data(mwd),
        .o_busy(busy), .o_halted(halted), .o_fault(fault)
`ifdef PERF_CNT_EN
        , .o_cycle_cnt(cyc), .o_retire_cnt(ret)
`endif
    );

    instr_sequencer #(.AW(2), .RESET_PC(2'd0), .MEM_TIMEOUT(0)) u_dut_aw2 (
        .clk(clk), .rst_n(rst_n), .i_start(start1),
        .o_imem_req(req1), .o_imem_addr(addr1), .i_imem_ack(ack1), .i_imem_rdata(rdata1),
        .o_instr(instr1), .o_alu_op(alu_op1), .o_reg_write(reg_write1),
        .o_mux_write_reg(mwr1), .o_mux_write_data(mwd1),
        .o_busy(busy1), .o_halted(halted1), .o_fault(fault1)
`ifdef PERF_CNT_EN
        , .o_cycle_cnt(cyc1), .o_retire_cnt(ret1)
`endif
    );

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] f);
        return {op, 23'd0, f};
    endfunction

    function automatic wr_t mk_wr(input logic [3:0] a, input logic m1, input logic m2,
                                  input logic [31:0] ir);
        wr_t w;
        w.alu = a; w.mwr = m1; w.mwd = m2; w.ir = ir;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halted(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!halted) begin
            bad++;
            $display("FAIL %s: halted=%0b after %0d cycles, required 1", name, halted, n);
        end else begin
            $display("ok   %s: halted after %0d cycles", name, n);
        end
    endtask

    // Monitor for main DUT: every accepted fetch and every write strobe pops the scoreboard
    always @(negedge clk) begin : mon_main
        int  e;
        wr_t w;
        if (req && ack) begin
            if (exp_fetch.size() == 0) begin
                total++; bad++;
                $display("FAIL fetch_unexpected: got addr %0d, required no fetch", addr);
            end else begin
                e = exp_fetch.pop_front();
                check("fetch_addr", {24'd0, addr}, e);
            end
        end
        if (reg_write) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
                total++; bad++;
                $display("FAIL wr_unexpected: got write alu_op=%0h, required no write", alu_op);
            end else begin
                w = exp_wr.pop_front();
                check("wr_alu_op", {28'd0, alu_op}, {28'd0, w.alu});
                check("wr_mux", {30'd0, mwr, mwd}, {30'd0, w.mwr, w.mwd});
                check("wr_instr", instr, w.ir);
            end
        end
    end

    // Monitor for AW=2 DUT: checks only while expectations are pending
    always @(negedge clk) begin : mon_aw2
        int         e;
        logic [3:0] a;
        if (req1 && ack1 && exp_fetch1.size() != 0) begin
            e = exp_fetch1.pop_front();
            check("aw2_fetch_addr", {30'd0, addr1}, e);
        end
        if (reg_write1 && exp_alu1.size() != 0) begin
            a = exp_alu1.pop_front();
            check("aw2_wr_alu_op", {28'd0, alu_op1}, {28'd0, a});
            check("aw2_wr_instr", instr1, enc(OP_AR, a));
            check("aw2_wr_mux", {30'd0, mwr1, mwd1}, 32'd0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        for (int i = 0; i < 256; i++) mem[i] = enc(OP_HLT, 4'h0);
        for (int i = 0; i < 4; i++)   mem1[i] = enc(OP_AR, 4'(i));

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, req}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_halted", {31'd0, halted}, 0);
        check("rst_fault", {31'd0, fault}, 0);
        check("rst_reg_write", {31'd0, reg_write}, 0);
        check("rst_instr", instr, 0);
        check("rst_alu_op", {28'd0, alu_op}, 0);
        check("rst_mux", {30'd0, mwr, mwd}, 0);
        check("rst_addr", {24'd0, addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // AR then T then HLT, zero-wait ack
        mem[0] = enc(OP_AR, 4'b0001);
        mem[1] = enc(OP_T, 4'h0);
        mem[2] = enc(OP_HLT, 4'h0);
        ack_delay = 0;
        exp_fetch.push_back(0); exp_fetch.push_back(1); exp_fetch.push_back(2);
        exp_wr.push_back(mk_wr(4'b0001, 1'b0, 1'b0, mem[0]));
        exp_wr.push_back(mk_wr(4'b1111, 1'b1, 1'b1, mem[1]));
        pulse_start();
        check("t1_req_c1", {31'd0, req}, 1);
        check("t1_addr_c1", {24'd0, addr}, 0);
        check("t1_busy_c1", {31'd0, busy}, 1);
        @(negedge clk); @(negedge clk);
        check("t1_no_wr_c3", {31'd0, reg_write}, 0);
        @(negedge clk);
        check("t1_wr_c4", {31'd0, reg_write}, 1);
        @(negedge clk);
        check("t1_wr_drop_c5", {31'd0, reg_write}, 0);
        check("t1_next_addr", {24'd0, addr}, 1);
        wait_halted("t2_halt", 40);
        check("t2_busy_halt", {31'd0, busy}, 0);
        check("t2_fault_halt", {31'd0, fault}, 0);
        check("t2_pc_halt", {24'd0, addr}, 2);
        check("t2_alu_hold", {28'd0, alu_op}, 4'hF);
        check("t2_wr_count", wr_seen, 2);

        // Ack delayed by 3 cycles: request held 4 cycles, write in cycle 7
        ack_delay = 3;
        exp_fetch.push_back(0); exp_fetch.push_back(1); exp_fetch.push_back(2);
        exp_wr.push_back(mk_wr(4'b0001, 1'b0, 1'b0, mem[0]));
        exp_wr.push_back(mk_wr(4'b1111, 1'b1, 1'b1, mem[1]));
        pulse_start();
        for (int k = 1; k <= 7; k++) begin
            if (k <= 4) begin
                check("t3_req_held", {31'd0, req}, 1);
                check("t3_addr_held", {24'd0, addr}, 0);
            end else begin
                check("t3_wr_timing", {31'd0, reg_write}, (k == 7) ? 1 : 0);
            end
            if (k < 7) @(negedge clk);
        end
        wait_halted("t3_halt", 80);

        // Ack never comes: timeout after 4 FETCH cycles
        ack_delay = -1;
        wr_before = wr_seen;
        pulse_start();
        check("t3b_fault_cleared", {31'd0, fault}, 0);
        for (int k = 1; k <= 4; k++) begin
            check("t3b_req_fetch", {31'd0, req}, 1);
            @(negedge clk);
        end
        check("t3b_halted", {31'd0, halted}, 1);
        check("t3b_fault", {31'd0, fault}, 1);
        check("t3b_req_drop", {31'd0, req}, 0);
        check("t3b_no_wr", wr_seen, wr_before);

        // Illegal opcode then HLT: fault, no write, PC advanced once
        ack_delay = 0;
        mem[0] = enc(OP_ILL, 4'h5);
        mem[1] = enc(OP_HLT, 4'h0);
        exp_fetch.push_back(0); exp_fetch.push_back(1);
        pulse_start();
        check("t4_fault_cleared", {31'd0, fault}, 0);
        wait_halted("t4_halt", 40);
        check("t4_fault", {31'd0, fault}, 1);
        check("t4_pc", {24'd0, addr}, 1);
        check("t4_no_wr", wr_seen, wr_before);

        // AR with out-of-range funct is illegal
        mem[0] = enc(OP_AR, 4'b1001);
        exp_fetch.push_back(0); exp_fetch.push_back(1);
        pulse_start();
        wait_halted("t4b_halt", 40);
        check("t4b_fault", {31'd0, fault}, 1);
        check("t4b_no_wr", wr_seen, wr_before);

        // Restart clears fault and refetches from address 0
        mem[0] = enc(OP_AR, 4'b0010);
        exp_fetch.push_back(0); exp_fetch.push_back(1);
        exp_wr.push_back(mk_wr(4'b0010, 1'b0, 1'b0, mem[0]));
        pulse_start();
        check("t4c_fault_cleared", {31'd0, fault}, 0);
        check("t4c_addr", {24'd0, addr}, 0);
        wait_halted("t4c_halt", 40);
        check("t4c_fault_end", {31'd0, fault}, 0);
        check("t4c_wr", wr_seen, wr_before + 1);

        // Reset during EXEC aborts without a write
        mem[0] = enc(OP_AR, 4'b0011);
        exp_fetch.push_back(0);
        wr_before = wr_seen;
        pulse_start();
        @(negedge clk); @(negedge clk);
        check("t6_busy_exec", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("t6_busy_rst", {31'd0, busy}, 0);
        check("t6_alu_rst", {28'd0, alu_op}, 0);
        check("t6_instr_rst", instr, 0);
        @(negedge clk); @(negedge clk);
        check("t6_no_wr", wr_seen, wr_before);
        rst_n = 1'b1;

        // Reset during FETCH drops the request at once
        ack_delay = -1;
        pulse_start();
        check("t6_req_fetch", {31'd0, req}, 1);
        rst_n = 1'b0;
        #1;
        check("t6_req_async", {31'd0, req}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        @(negedge clk);

        exp_fetch.push_back(0); exp_fetch.push_back(1);
        exp_wr.push_back(mk_wr(4'b0011, 1'b0, 1'b0, mem[0]));
        pulse_start();
        check("t6_refetch_addr", {24'd0, addr}, 0);
        wait_halted("t6_halt", 40);
        check("t6_wr_after", wr_seen, wr_before + 1);

`ifdef PERF_CNT_EN
        mem[0] = enc(OP_AR, 4'b0001);
        mem[1] = enc(OP_AR, 4'b0010);
        mem[2] = enc(OP_AR, 4'b0100);
        mem[3] = enc(OP_HLT, 4'h0);
        for (int i = 0; i < 4; i++) exp_fetch.push_back(i);
        exp_wr.push_back(mk_wr(4'b0001, 1'b0, 1'b0, mem[0]));
        exp_wr.push_back(mk_wr(4'b0010, 1'b0, 1'b0, mem[1]));
        exp_wr.push_back(mk_wr(4'b0100, 1'b0, 1'b0, mem[2]));
        pulse_start();
        check("perf_cycle_clr", cyc, 0);
        check("perf_retire_clr", ret, 0);
        repeat (12) @(negedge clk);
        check("perf_cycle_12", cyc, 12);
        check("perf_retire_3", ret, 3);
        wait_halted("perf_halt", 40);
`endif

        // AW=2 instance: fetch addresses wrap 3 -> 0
        for (int i = 0; i < 4; i++) begin
            exp_fetch1.push_back(i);
            exp_alu1.push_back(4'(i));
        end
        exp_fetch1.push_back(0);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while ((exp_fetch1.size() != 0 || exp_alu1.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5_pending_left", exp_fetch1.size() + exp_alu1.size(), 0);
        check("t5_running", {29'd0, busy1, halted1, fault1}, 32'b100);

        check("sb_fetch_drained", exp_fetch.size(), 0);
        check("sb_wr_drained", exp_wr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
